// File: rtl/enoc_switch_allocator.sv
// Per-router switch allocator: per-output round-robin matching of input queue heads to outputs.
// Optional age-based anti-starvation override is compiled in with ENOC_ALLOC_STARVE_EN.

module enoc_alloc_arb #(
   parameter int N  = 7,
   parameter int PW = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [0:N-1] cand,
   input  logic         en,
   output logic [0:N-1] sel,
   output logic         vld,
   output logic         xfer
);
   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [0:N-1]  sel_raw;
   logic          found;
   int            idx;

   // First candidate at or after ptr, wrapping N-1 -> 0.
   always_comb begin
      sel_raw = '0;
      win     = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && cand[idx]) begin
            found        = 1'b1;
            win          = PW'(idx);
            sel_raw[idx] = 1'b1;
         end
      end
   end

   assign sel  = reset ? '0 : sel_raw;
   assign vld  = found & ~reset;
   assign xfer = vld & en;

   always_ff @(posedge clk) begin
      if (reset)     ptr <= '0;
      else if (xfer) ptr <= (win == PW'(N-1)) ? '0 : win + PW'(1);
   end
endmodule

module enoc_switch_allocator #(
   parameter int N            = 7,
   parameter int M            = 7,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [0:N-1][0:M-1]  i_req,
   input  logic [0:M-1]         i_en,
   output logic [0:M-1][0:N-1]  o_sel,
   output logic [0:M-1]         o_data_val,
   output logic [0:N-1]         o_grant,
   output logic [0:N-1]         o_starve
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [0:N-1][0:M-1] req_s;
   logic [0:N-1]        has_req;
   logic [0:N-1]        urg;
   logic [0:M-1][0:N-1] cand;
   logic [0:M-1]        xfer;

   // Keep only the lowest-index request per input so each input grants at most once.
   always_comb begin
      req_s   = '0;
      has_req = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < M; j++)
            if (i_req[i][j] && !has_req[i]) begin
               req_s[i][j] = 1'b1;
               has_req[i]  = 1'b1;
            end
   end

   // Urgent candidates, if any exist for an output, exclude the non-urgent ones.
   always_comb begin
      cand = '0;
      for (int j = 0; j < M; j++) begin
         logic any_urg;
         any_urg = 1'b0;
         for (int i = 0; i < N; i++)
            if (req_s[i][j] && urg[i]) any_urg = 1'b1;
         for (int i = 0; i < N; i++)
            cand[j][i] = req_s[i][j] & (urg[i] | ~any_urg);
      end
   end

   for (genvar j = 0; j < M; j++) begin : g_out
      enoc_alloc_arb #(.N(N), .PW(PW)) u_arb (
         .clk   (clk),
         .reset (reset),
         .cand  (cand[j]),
         .en    (i_en[j]),
         .sel   (o_sel[j]),
         .vld   (o_data_val[j]),
         .xfer  (xfer[j])
      );
   end

   always_comb begin
      o_grant = '0;
      for (int j = 0; j < M; j++)
         for (int i = 0; i < N; i++)
            if (xfer[j] && o_sel[j][i]) o_grant[i] = 1'b1;
   end

`ifdef ENOC_ALLOC_STARVE_EN
   localparam int AW = $clog2(STARVE_LIMIT + 1);
   localparam logic [AW-1:0] LIM = AW'(STARVE_LIMIT);

   logic [0:N-1][AW-1:0] age;

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (reset || !has_req[i] || o_grant[i]) age[i] <= '0;
         else if (age[i] != LIM)                 age[i] <= age[i] + AW'(1);
      end
   end

   always_comb begin
      urg = '0;
      for (int i = 0; i < N; i++) urg[i] = (age[i] == LIM) & ~reset;
   end
   assign o_starve = urg;
`else
   assign urg      = '0;
   assign o_starve = '0;
`endif
endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Directed bench for enoc_switch_allocator (N=M=7, STARVE_LIMIT=3); expectations follow ENOC_ALLOC_STARVE_EN.
module tb_enoc_switch_allocator;
   localparam int N = 7;
   localparam int M = 7;

   logic                clk = 1'b0;
   logic                reset;
   logic [0:N-1][0:M-1] i_req;
   logic [0:M-1]        i_en;
   logic [0:M-1][0:N-1] o_sel;
   logic [0:M-1]        o_data_val;
   logic [0:N-1]        o_grant;
   logic [0:N-1]        o_starve;

   int n_chk  = 0;
   int n_pass = 0;

   enoc_switch_allocator #(.N(N), .M(M), .STARVE_LIMIT(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_req      (i_req),
      .i_en       (i_en),
      .o_sel      (o_sel),
      .o_data_val (o_data_val),
      .o_grant    (o_grant),
      .o_starve   (o_starve)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [0:N-1] oh(input int k);
      logic [0:N-1] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // Advance one edge; inputs change 1ns after it, checks land mid-cycle.
   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   localparam int FAIR_SEQ [6] = '{1, 3, 5, 1, 3, 5};

   initial begin
      reset = 1'b1;
      i_req = '1;
      i_en  = '1;

      for (int c = 0; c < 3; c++) begin
         #4;
         chk($sformatf("rst_sel%0d", c), o_sel, '0);
         chk($sformatf("rst_val%0d", c), o_data_val, '0);
         chk($sformatf("rst_gnt%0d", c), o_grant, '0);
         adv();
      end
      reset = 1'b0;
      #4;
      chk("rel_sel0", o_sel[0], oh(0));
      chk("rel_gnt", o_grant, oh(0));
      adv();

      // Fairness on output 2
      i_req = '0;
      adv();
      i_req[1][2] = 1'b1;
      i_req[3][2] = 1'b1;
      i_req[5][2] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #4;
         chk($sformatf("fair_gnt%0d", c), o_grant, oh(FAIR_SEQ[c]));
         chk($sformatf("fair_val%0d", c), o_data_val[2], 1'b1);
         adv();
      end

      // Backpressure
      i_en[2] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #4;
         chk($sformatf("bp_sel%0d", c), o_sel[2], oh(1));
         chk($sformatf("bp_gnt%0d", c), o_grant, '0);
         chk($sformatf("bp_val%0d", c), o_data_val[2], 1'b1);
         adv();
      end
      i_en[2] = 1'b1;
      #4;
      chk("bp_rise_gnt0", o_grant, oh(1));
      adv();
      #4;
      chk("bp_rise_gnt1", o_grant, oh(3));
      adv();

      // Parallel grants and request sanitising
      i_req = '0;
      adv();
      i_req[0][1] = 1'b1;
      i_req[4][3] = 1'b1;
      i_req[2][1] = 1'b1;
      i_req[2][4] = 1'b1;
      #4;
      chk("par_sel1", o_sel[1], oh(0));
      chk("par_sel3", o_sel[3], oh(4));
      chk("par_val4", o_data_val[4], 1'b0);
      chk("par_gnt", o_grant, oh(0) | oh(4));
      adv();
      #4;
      chk("par2_sel1", o_sel[1], oh(2));
      chk("par2_gnt", o_grant, oh(2) | oh(4));
      adv();

      // Reset mid-transfer, which also returns ptr[0] to 0
      i_req = '0;
      i_req[6][0] = 1'b1;
      reset = 1'b1;
      #4;
      chk("rst_mid_gnt", o_grant, '0);
      chk("rst_mid_val", o_data_val, '0);
      adv();
      reset = 1'b0;

      // Starvation: input 6 waits on output 0
      i_en[0] = 1'b0;
      for (int c = 0; c < 3; c++) adv();
      #4;
`ifdef ENOC_ALLOC_STARVE_EN
      chk("starve_flag", o_starve, oh(6));
`else
      chk("starve_flag", o_starve, '0);
`endif
      i_req[0][0] = 1'b1;
      i_en[0]     = 1'b1;
      #1;
`ifdef ENOC_ALLOC_STARVE_EN
      chk("starve_gnt0", o_grant, oh(6));
`else
      chk("starve_gnt0", o_grant, oh(0));
`endif
      adv();
      #4;
`ifdef ENOC_ALLOC_STARVE_EN
      chk("starve_gnt1", o_grant, oh(0));
`else
      chk("starve_gnt1", o_grant, oh(6));
      chk("starve_zero", o_starve, '0);
`endif
      adv();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
